a2_encoder: RTL and testbench
=============================

# a2_encoder

Serial sign-magnitude to two's-complement encoder. It is the inverse of the MDR datapath's A2-to-magnitude stage: it takes the unsigned magnitude and sign that the multiplier/divider/root core produces and packs them back into an IVW-bit two's-complement word. It processes one bit per clock (LSB first, "copy through first 1, invert the rest"), flags results that cannot be represented, and holds the result for the downstream register or display path.

## Interface
- IVW, 8 (from pkg_system_mdr): data width in bits; must be at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_Start  in  1  single-cycle request to convert; sampled in IDLE and DONE only.
- i_Mag  in  IVW  unsigned magnitude; captured on the accepted i_Start.
- i_Signo  in  1  sign, captured with i_Mag; 1 = positive, 0 = negative (MDR sign convention).
- o_Val  out  IVW  two's-complement result; valid from DONE and held until the next accepted start.
- o_Ovf  out  1  result not representable; valid and held with o_Val.
- o_Busy  out  1  high while in CONV.
- o_Done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, CONV, DONE. The state enum lives in the package.
- IDLE, with i_Start=1:
  - Capture i_Mag into a shift register and i_Signo into a sign flop.
  - Clear the bit counter and the "seen-one" flag.
  - Go to CONV.
- CONV, each cycle, for bit b = shift[0]:
  - Positive: emit b.
  - Negative and seen-one=0: emit b, then set seen-one if b=1.
  - Negative and seen-one=1: emit ~b.
  - The emitted bit shifts into the result register MSB-first-in, so after IVW shifts the LSB sits at bit 0.
  - The counter increments each cycle. After the cycle where the counter is IVW-1, go to DONE.
- DONE:
  - Pulse o_Done.
  - Go to IDLE, or straight back to CONV if i_Start=1, with the same capture as IDLE.
- i_Start in CONV is ignored. Nothing is queued.
- Overflow, computed from the captured magnitude and latched at entry to DONE:
  - Positive: o_Ovf = Mag[IVW-1].
  - Negative: o_Ovf = Mag > 2^(IVW-1).
- Boundaries:
  - Negative zero (Mag=0, Signo=0) gives 0, o_Ovf=0.
  - Mag = 2^(IVW-1) negative gives 100…0, o_Ovf=0 (most-negative value is legal).
- Reset at any point, including mid-CONV:
  - State goes to IDLE. The conversion is abandoned with no o_Done.
  - o_Val=0, o_Ovf=0, o_Busy=0, o_Done=0.
  - Shift register, counter, seen-one and sign flop are all cleared.

## Timing
- Start accepted at edge T. o_Busy is high for cycles T+1 … T+IVW. o_Done is high in cycle T+IVW+1.
- Latency is therefore IVW+1 cycles from start to done: 9 for IVW=8.
- Throughput is one conversion per IVW+1 cycles when restarting from DONE.
- o_Val/o_Ovf update only on the DONE entry edge and are stable otherwise. Downstream samples them on o_Done or any time after.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- A2_ENCODER_SAT_EN defined: an overflowed result saturates.
  - Positive overflow: o_Val = 0111…1.
  - Negative overflow: o_Val = 100…0.
- A2_ENCODER_SAT_EN undefined: o_Val is the raw serial result (modulo 2^IVW wrap).
- o_Ovf behaves identically in both builds.

## Structure
- pkg_system_mdr holds:
  - IVW.
  - The state typedef (IDLE/CONV/DONE).
  - Counter width localparam $clog2(IVW).
  - Saturation constants MAX_POS and MIN_NEG.
- Single module, no sub-modules. The bit step is one small always_comb next-bit expression feeding the FSM/datapath always_ff.

## Test plan
- Mag=5, Signo=1 -> o_Val=0x05, o_Ovf=0; o_Done exactly 9 cycles after the start edge; o_Busy high for 8 cycles.
- Mag=5, Signo=0 -> 0xFB. Mag=1, Signo=0 -> 0xFF. Mag=0, Signo=0 -> 0x00. All with o_Ovf=0.
- Mag=128, Signo=0 -> 0x80, o_Ovf=0. Mag=128, Signo=1 -> o_Ovf=1, o_Val=0x7F with the macro, 0x80 without.
- Mag=200, Signo=0 -> o_Ovf=1, o_Val=0x80 with the macro, 0x38 without.
- Start (Mag=3, +) then a second start (Mag=9, −) 3 cycles later -> second ignored; o_Val=0x03. Start in the DONE cycle -> back-to-back, next o_Done 9 cycles later.
- rst pulsed in cycle 4 of CONV -> all outputs 0 immediately, no o_Done; a fresh start then converts correctly.

Source files
------------

// File: rtl/pkg_system_mdr.sv
// Shared MDR system definitions: data width, encoder state type,
// counter width and two's-complement saturation limits.
package pkg_system_mdr;

    localparam int IVW   = 8;
    localparam int CNT_W = $clog2(IVW);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam logic [IVW-1:0] MAX_POS = {1'b0, {(IVW-1){1'b1}}};
    localparam logic [IVW-1:0] MIN_NEG = {1'b1, {(IVW-1){1'b0}}};

endpackage

// File: rtl/a2_encoder.sv
// Serial sign-magnitude to two's-complement encoder, one bit per clock.
// Build option: define A2_ENCODER_SAT_EN to saturate overflowed results.
module a2_encoder
    import pkg_system_mdr::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_Start,
    input  logic [IVW-1:0] i_Mag,
    input  logic           i_Signo,
    output logic [IVW-1:0] o_Val,
    output logic           o_Ovf,
    output logic           o_Busy,
    output logic           o_Done
);

    state_t             state_q;
    logic [IVW-1:0]     shift_q;
    logic [IVW-1:0]     mag_q;
    logic [IVW-1:0]     res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               seen_q;
    logic               sign_q;
    logic [IVW-1:0]     val_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic               bit_b;
    logic               nbit;
    logic [IVW-1:0]     res_d;
    logic [IVW-1:0]     val_d;
    logic               ovf_d;
    logic               last;

    // Next serial bit: copy through the first 1, then invert (negative only)
    always_comb begin
        bit_b = shift_q[0];
        nbit  = (!sign_q && seen_q) ? ~bit_b : bit_b;
        res_d = {nbit, res_q[IVW-1:1]};
        last  = (cnt_q == CNT_W'(IVW - 1));
        ovf_d = sign_q ? mag_q[IVW-1]
                       : (mag_q[IVW-1] && (|mag_q[IVW-2:0]));
`ifdef A2_ENCODER_SAT_EN
        if (ovf_d) begin
            val_d = sign_q ? MAX_POS : MIN_NEG;
        end else begin
            val_d = res_d;
        end
`else
        val_d = res_d;
`endif
    end

    // Control FSM and serial datapath with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            mag_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            sign_q  <= 1'b0;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (i_Start) begin
                        shift_q <= i_Mag;
                        mag_q   <= i_Mag;
                        sign_q  <= i_Signo;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        seen_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CONV: begin
                    shift_q <= shift_q >> 1;
                    res_q   <= res_d;
                    seen_q  <= seen_q | bit_b;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last) begin
                        val_q   <= val_d;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_Val  = val_q;
    assign o_Ovf  = ovf_q;
    assign o_Busy = busy_q;
    assign o_Done = done_q;

endmodule

// File: tb/tb_a2_encoder.sv
// Scoreboard testbench for a2_encoder: directed conversions, overflow
// boundaries, ignored/back-to-back starts and mid-conversion reset.
module tb_a2_encoder;
    import pkg_system_mdr::*;

    typedef struct {
        logic [IVW-1:0] val;
        logic           ovf;
        int             scyc;
        string          name;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           i_Start;
    logic [IVW-1:0] i_Mag;
    logic           i_Signo;
    logic [IVW-1:0] o_Val;
    logic           o_Ovf;
    logic           o_Busy;
    logic           o_Done;

    exp_t sb_q[$];
    int   n_pass;
    int   n_total;
    int   cyc;
    int   busy_cnt;
    int   done_cnt;

    a2_encoder dut (
        .clk     (clk),
        .rst     (rst),
        .i_Start (i_Start),
        .i_Mag   (i_Mag),
        .i_Signo (i_Signo),
        .o_Val   (o_Val),
        .o_Ovf   (o_Ovf),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every o_Done pulse
    initial begin
        exp_t e;
        busy_cnt = 0;
        done_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (o_Busy) busy_cnt++;
                if (o_Done) begin
                    done_cnt++;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk({e.name, "_val"}, int'(o_Val), int'(e.val));
                        chk({e.name, "_ovf"}, int'(o_Ovf), int'(e.ovf));
                        chk({e.name, "_latency"}, cyc - e.scyc, IVW + 1);
                        chk({e.name, "_busy"}, busy_cnt, IVW);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    // Drive a start for one cycle from a negedge, pushing the expectation
    task automatic issue(input string name, input int mag, input bit sg,
                         input int ev, input bit eo);
        exp_t e;
        e.val  = IVW'(ev);
        e.ovf  = eo;
        e.scyc = cyc;
        e.name = name;
        sb_q.push_back(e);
        i_Start = 1'b1;
        i_Mag   = IVW'(mag);
        i_Signo = sg;
        @(negedge clk);
        i_Start = 1'b0;
    endtask

    // Wait (bounded) for o_Done; returns on the negedge where it is high
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_Done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic run(input string name, input int mag, input bit sg,
                       input int ev, input bit eo);
        @(negedge clk);
        issue(name, mag, sg, ev, eo);
        wait_done(name);
    endtask

    initial begin
        int dc;
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        i_Start  = 1'b0;
        i_Mag    = '0;
        i_Signo  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_val",  int'(o_Val),  0);
        chk("rst_ovf",  int'(o_Ovf),  0);
        chk("rst_busy", int'(o_Busy), 0);
        chk("rst_done", int'(o_Done), 0);
        rst = 1'b0;

        run("p5",   5,   1'b1, 'h05, 1'b0);
        run("n5",   5,   1'b0, 'hFB, 1'b0);
        run("n1",   1,   1'b0, 'hFF, 1'b0);
        run("n0",   0,   1'b0, 'h00, 1'b0);
        run("n128", 128, 1'b0, 'h80, 1'b0);
`ifdef A2_ENCODER_SAT_EN
        run("p128", 128, 1'b1, 'h7F, 1'b1);
        run("n200", 200, 1'b0, 'h80, 1'b1);
`else
        run("p128", 128, 1'b1, 'h80, 1'b1);
        run("n200", 200, 1'b0, 'h38, 1'b1);
`endif

        // Second start during CONV must be ignored
        @(negedge clk);
        issue("ign", 3, 1'b1, 'h03, 1'b0);
        repeat (2) @(negedge clk);
        i_Start = 1'b1;
        i_Mag   = 8'd9;
        i_Signo = 1'b0;
        @(negedge clk);
        i_Start = 1'b0;
        wait_done("ign");

        // Restart straight from DONE, twice
        issue("b2b1", 127, 1'b0, 'h81, 1'b0);
        wait_done("b2b1");
`ifdef A2_ENCODER_SAT_EN
        issue("b2b2", 255, 1'b1, 'h7F, 1'b1);
`else
        issue("b2b2", 255, 1'b1, 'hFF, 1'b1);
`endif
        wait_done("b2b2");

        // Reset in the middle of a conversion
        @(negedge clk);
        i_Start = 1'b1;
        i_Mag   = 8'd7;
        i_Signo = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", int'(o_Busy), 1);
        dc  = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_rst_val",  int'(o_Val),  0);
        chk("mid_rst_ovf",  int'(o_Ovf),  0);
        chk("mid_rst_busy", int'(o_Busy), 0);
        chk("mid_rst_done", int'(o_Done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_done_after_rst", done_cnt, dc);
        chk("idle_after_rst", int'(o_Busy), 0);

        run("post_rst", 5, 1'b0, 'hFB, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
